// File: rtl/operand_forward_ctrl.sv
// Operand-forwarding select generator for the EX-stage ALU muxes, with
// one-cycle load-use stall detection and a saturating stall counter.
`default_nettype none

module operand_forward_ctrl #(
  parameter int REG_BITS  = 3,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_valid,
  input  logic [REG_BITS-1:0]  id_rs,
  input  logic                 id_rs_used,
  input  logic [REG_BITS-1:0]  id_rt,
  input  logic                 id_rt_used,
  input  logic [REG_BITS-1:0]  id_rd,
  input  logic                 id_reg_we,
  input  logic                 id_is_load,
  input  logic                 id_sel_pc_a,
  input  logic                 id_sel_imm_b,
  input  logic                 flush,
  input  logic                 cnt_clr,
  output logic                 stall,
  output logic                 ex_valid,
  output logic [1:0]           ex_sel_a,
  output logic [1:0]           ex_sel_b,
  output logic [CNT_WIDTH-1:0] stall_count
);

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_EX  = 2'b01;
  localparam logic [1:0] SEL_MEM = 2'b10;
  localparam logic [1:0] SEL_ALT = 2'b11;

  logic                 ex_v_q,   ex_v_d;
  logic [REG_BITS-1:0]  ex_rd_q,  ex_rd_d;
  logic                 ex_we_q,  ex_we_d;
  logic                 ex_ld_q,  ex_ld_d;
  logic                 mem_v_q,  mem_v_d;
  logic [REG_BITS-1:0]  mem_rd_q, mem_rd_d;
  logic                 mem_we_q, mem_we_d;
  logic                 exv_q,    exv_d;
  logic [1:0]           sel_a_q,  sel_a_d;
  logic [1:0]           sel_b_q,  sel_b_d;
  logic [CNT_WIDTH-1:0] cnt_q,    cnt_d;

  logic ex_fwd_ok;
  logic mem_fwd_ok;
  logic hz_a;
  logic hz_b;
  logic bubble;

  assign ex_fwd_ok  = ex_v_q & ex_we_q;
  assign mem_fwd_ok = mem_v_q & mem_we_q;

  // An operand replaced by PC+2 / immediate never depends on the load.
  assign hz_a   = id_rs_used & (id_rs == ex_rd_q) & ~id_sel_pc_a;
  assign hz_b   = id_rt_used & (id_rt == ex_rd_q) & ~id_sel_imm_b;
  assign stall  = id_valid & ~flush & ex_fwd_ok & ex_ld_q & (hz_a | hz_b);
  assign bubble = flush | stall | ~id_valid;

  function automatic logic [1:0] fwd_sel(input logic                ovr,
                                         input logic                used,
                                         input logic [REG_BITS-1:0] r);
    if (ovr)                                 return SEL_ALT;
    else if (used && ex_fwd_ok  && r == ex_rd_q)  return SEL_EX;
    else if (used && mem_fwd_ok && r == mem_rd_q) return SEL_MEM;
    else                                     return SEL_RF;
  endfunction

  always_comb begin
    mem_v_d  = ex_v_q;
    mem_rd_d = ex_rd_q;
    mem_we_d = ex_we_q;
    ex_v_d   = 1'b0;
    ex_rd_d  = ex_rd_q;
    ex_we_d  = ex_we_q;
    ex_ld_d  = ex_ld_q;
    exv_d    = 1'b0;
    sel_a_d  = SEL_RF;
    sel_b_d  = SEL_RF;
    if (!bubble) begin
      ex_v_d  = 1'b1;
      ex_rd_d = id_rd;
      ex_we_d = id_reg_we;
      ex_ld_d = id_is_load;
      exv_d   = 1'b1;
      sel_a_d = fwd_sel(id_sel_pc_a,  id_rs_used, id_rs);
      sel_b_d = fwd_sel(id_sel_imm_b, id_rt_used, id_rt);
    end

    cnt_d = cnt_q;
    if (cnt_clr)
      cnt_d = '0;
    else if (stall && (cnt_q != {CNT_WIDTH{1'b1}}))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_v_q   <= 1'b0;
      ex_rd_q  <= '0;
      ex_we_q  <= 1'b0;
      ex_ld_q  <= 1'b0;
      mem_v_q  <= 1'b0;
      mem_rd_q <= '0;
      mem_we_q <= 1'b0;
      exv_q    <= 1'b0;
      sel_a_q  <= SEL_RF;
      sel_b_q  <= SEL_RF;
      cnt_q    <= '0;
    end else begin
      ex_v_q   <= ex_v_d;
      ex_rd_q  <= ex_rd_d;
      ex_we_q  <= ex_we_d;
      ex_ld_q  <= ex_ld_d;
      mem_v_q  <= mem_v_d;
      mem_rd_q <= mem_rd_d;
      mem_we_q <= mem_we_d;
      exv_q    <= exv_d;
      sel_a_q  <= sel_a_d;
      sel_b_q  <= sel_b_d;
      cnt_q    <= cnt_d;
    end
  end

  assign ex_valid    = exv_q;
  assign ex_sel_a    = sel_a_q;
  assign ex_sel_b    = sel_b_q;
  assign stall_count = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_operand_forward_ctrl.sv
// Directed bench for operand_forward_ctrl: per-cycle model comparison plus literal checks.
`default_nettype none

module tb_operand_forward_ctrl;
  localparam int RB = 3;
  localparam int CW = 8;  // narrow counter so saturation is reachable in a short run

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic id_valid = 0, id_rs_used = 0, id_rt_used = 0, id_reg_we = 0, id_is_load = 0;
  logic id_sel_pc_a = 0, id_sel_imm_b = 0, flush = 0, cnt_clr = 0;
  logic [RB-1:0] id_rs = 0, id_rt = 0, id_rd = 0;
  logic stall, ex_valid;
  logic [1:0] ex_sel_a, ex_sel_b;
  logic [CW-1:0] stall_count;

  int total = 0;
  int bad   = 0;

  operand_forward_ctrl #(.REG_BITS(RB), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
    .id_rt(id_rt), .id_rt_used(id_rt_used), .id_rd(id_rd), .id_reg_we(id_reg_we),
    .id_is_load(id_is_load), .id_sel_pc_a(id_sel_pc_a), .id_sel_imm_b(id_sel_imm_b),
    .flush(flush), .cnt_clr(cnt_clr), .stall(stall), .ex_valid(ex_valid),
    .ex_sel_a(ex_sel_a), .ex_sel_b(ex_sel_b), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  // Model: in-flight instructions, index 0 = EX (youngest), 1 = MEM.
  typedef struct packed {
    logic          v;
    logic [RB-1:0] rd;
    logic          we;
    logic          ld;
  } slot_t;

  slot_t pipe [2];
  logic  m_exv;
  logic [1:0] m_sa, m_sb;
  int    m_cnt;

  function automatic int youngest_writer(input logic [RB-1:0] r);
    for (int i = 0; i < 2; i++)
      if (pipe[i].v && pipe[i].we && pipe[i].rd == r) return i;
    return -1;
  endfunction

  function automatic logic operand_waits(input logic used, input logic ovr, input logic [RB-1:0] r);
    return used && !ovr && youngest_writer(r) == 0 && pipe[0].ld;
  endfunction

  function automatic logic model_stall();
    return id_valid && !flush &&
           (operand_waits(id_rs_used, id_sel_pc_a, id_rs) ||
            operand_waits(id_rt_used, id_sel_imm_b, id_rt));
  endfunction

  function automatic logic [1:0] model_sel(input logic ovr, input logic used, input logic [RB-1:0] r);
    int y;
    if (ovr) return 2'b11;
    if (!used) return 2'b00;
    y = youngest_writer(r);
    return (y == 0) ? 2'b01 : (y == 1) ? 2'b10 : 2'b00;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      pipe[0] = '0; pipe[1] = '0;
      m_exv = 0; m_sa = 0; m_sb = 0; m_cnt = 0;
    end else begin
      logic s;
      s = model_stall();
      if (cnt_clr) m_cnt = 0;
      else if (s && m_cnt < (1 << CW) - 1) m_cnt = m_cnt + 1;
      if (flush || s || !id_valid) begin
        m_exv = 0; m_sa = 0; m_sb = 0;
        pipe[1] = pipe[0]; pipe[1].ld = 1'b0;
        pipe[0] = '0;
      end else begin
        m_exv = 1;
        m_sa = model_sel(id_sel_pc_a, id_rs_used, id_rs);
        m_sb = model_sel(id_sel_imm_b, id_rt_used, id_rt);
        pipe[1] = pipe[0]; pipe[1].ld = 1'b0;
        pipe[0] = '{v: 1'b1, rd: id_rd, we: id_reg_we, ld: id_is_load};
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("cyc_stall",    int'(stall),       int'(model_stall()));
    check("cyc_ex_valid", int'(ex_valid),    int'(m_exv));
    check("cyc_sel_a",    int'(ex_sel_a),    int'(m_sa));
    check("cyc_sel_b",    int'(ex_sel_b),    int'(m_sb));
    check("cyc_count",    int'(stall_count), m_cnt);
  end

  task automatic drive(input logic v, input logic [RB-1:0] rs, input logic rsu,
                       input logic [RB-1:0] rt, input logic rtu, input logic [RB-1:0] rd,
                       input logic we, input logic ld, input logic pca, input logic immb);
    id_valid = v; id_rs = rs; id_rs_used = rsu; id_rt = rt; id_rt_used = rtu;
    id_rd = rd; id_reg_we = we; id_is_load = ld; id_sel_pc_a = pca; id_sel_imm_b = immb;
    flush = 0; cnt_clr = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    #1;
    check("rst_ex_valid", int'(ex_valid), 0);
    check("rst_sel_a", int'(ex_sel_a), 0);
    check("rst_count", int'(stall_count), 0);
    tick(); tick();
    #3 rst = 1'b1;
    tick();

    // ALU forward from EX
    drive(1, 0, 0, 0, 0, 3, 1, 0, 0, 0); tick();
    drive(1, 3, 1, 5, 1, 6, 1, 0, 0, 0); #1;
    check("alu_fwd_stall", int'(stall), 0);
    tick();
    check("alu_fwd_sel_a", int'(ex_sel_a), 1);
    check("alu_fwd_sel_b", int'(ex_sel_b), 0);
    check("alu_fwd_valid", int'(ex_valid), 1);

    // Two-back forward from MEM
    drive(1, 0, 0, 0, 0, 2, 1, 0, 0, 0); tick();
    drive(1, 0, 0, 0, 0, 7, 1, 0, 0, 0); tick();
    drive(1, 0, 0, 2, 1, 1, 1, 0, 0, 0); tick();
    check("mem_fwd_sel_b", int'(ex_sel_b), 2);

    // Younger writer wins
    drive(1, 0, 0, 0, 0, 2, 1, 0, 0, 0); tick();
    drive(1, 0, 0, 0, 0, 2, 1, 0, 0, 0); tick();
    drive(1, 0, 0, 2, 1, 1, 1, 0, 0, 0); tick();
    check("prio_sel_b", int'(ex_sel_b), 1);

    // Load-use: one stall cycle, then forward from MEM
    drive(1, 0, 0, 0, 0, 4, 1, 1, 0, 0); tick();
    drive(1, 4, 1, 0, 0, 5, 1, 0, 0, 0); #1;
    check("lu_stall", int'(stall), 1);
    tick();
    check("lu_bubble_valid", int'(ex_valid), 0);
    check("lu_stall_drops", int'(stall), 0);
    tick();
    check("lu_sel_a", int'(ex_sel_a), 2);
    check("lu_count", int'(stall_count), 1);

    // Flush overrides stall
    drive(1, 0, 0, 0, 0, 4, 1, 1, 0, 0); tick();
    drive(1, 4, 1, 0, 0, 5, 1, 0, 0, 0); flush = 1; #1;
    check("flush_stall", int'(stall), 0);
    tick();
    check("flush_bubble", int'(ex_valid), 0);
    check("flush_count", int'(stall_count), 1);

    // Immediate operand B hides a load match
    drive(1, 0, 0, 0, 0, 5, 1, 1, 0, 0); tick();
    drive(1, 0, 0, 5, 1, 6, 1, 0, 0, 1); #1;
    check("imm_no_stall", int'(stall), 0);
    tick();
    check("imm_sel_b", int'(ex_sel_b), 3);

    // Saturation
    for (int i = 0; i < 260; i++) begin
      drive(1, 0, 0, 0, 0, 4, 1, 1, 0, 0); tick();
      drive(1, 4, 1, 0, 0, 5, 1, 0, 0, 0); tick();
    end
    check("sat_count", int'(stall_count), 255);

    // Clear wins over a simultaneous stall
    drive(1, 0, 0, 0, 0, 4, 1, 1, 0, 0); tick();
    drive(1, 4, 1, 0, 0, 5, 1, 0, 0, 0); cnt_clr = 1; #1;
    check("clr_stall", int'(stall), 1);
    tick();
    check("clr_count", int'(stall_count), 0);

    // Async reset mid-stall
    drive(1, 0, 0, 0, 0, 4, 1, 1, 0, 0); tick();
    drive(1, 4, 1, 0, 0, 5, 1, 0, 0, 0); tick();
    drive(1, 4, 1, 0, 0, 4, 1, 1, 0, 0); tick();
    drive(1, 4, 1, 0, 0, 5, 1, 0, 0, 0); #1;
    check("pre_rst_stall", int'(stall), 1);
    check("pre_rst_sel_a", int'(ex_sel_a), 2);
    #1 rst = 1'b0; #1;
    check("arst_stall", int'(stall), 0);
    check("arst_valid", int'(ex_valid), 0);
    check("arst_sel_a", int'(ex_sel_a), 0);
    check("arst_count", int'(stall_count), 0);
    tick();
    #3 rst = 1'b1;
    drive(1, 4, 1, 4, 1, 1, 1, 0, 0, 0);
    tick();
    check("post_rst_valid", int'(ex_valid), 1);
    check("post_rst_sel_a", int'(ex_sel_a), 0);
    check("post_rst_sel_b", int'(ex_sel_b), 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
